game_ctrl: RTL and testbench



---
 rtl/game_ctrl_pkg.sv | 22 ++
 rtl/game_ctrl_edge_detect.sv | 25 ++
 rtl/game_ctrl.sv | 142 ++++++++++++++
 tb/tb_game_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the game-state controller.
package game_ctrl_pkg;

    localparam int GAME_SCORE_WIDTH = 16;
    localparam int GAME_LIFE_WIDTH  = 2;
    localparam int GAME_LIVES_INIT  = 3;
    localparam int GAME_HIT_SCORE   = 1;
    localparam int GAME_INV_FRAMES  = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    // Crash strobes are only recorded while the enemies are moving.
    function automatic logic is_active(input state_t s);
        return (s == ST_PLAY) || (s == ST_HIT);
    endfunction

endpackage

// File: rtl/game_ctrl_edge_detect.sv
// Registered single-cycle edge detector; the sampling register resets to
// RST_LEVEL so an idle input never produces a spurious pulse after reset.
module edge_detect #(
    parameter bit FALLING   = 1'b0,
    parameter bit RST_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= RST_LEVEL;
            pulse <= 1'b0;
        end else begin
            d_q   <= d;
            pulse <= FALLING ? (d_q & ~d) : (~d_q & d);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: folds per-pixel crash strobes into per-frame events
// and updates score, lives and the IDLE/PLAY/HIT/OVER state on each frame tick.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int SCORE_WIDTH = GAME_SCORE_WIDTH,
    parameter int LIFE_WIDTH  = GAME_LIFE_WIDTH,
    parameter int LIVES_INIT  = GAME_LIVES_INIT,
    parameter int HIT_SCORE   = GAME_HIT_SCORE,
    parameter int INV_FRAMES  = GAME_INV_FRAMES
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   v_sync_i,
    input  logic                   crash_enemy_bullet_i,
    input  logic                   crash_me_enemy_i,
    output logic                   en_o,
    output logic                   frame_tick_o,
    output logic [SCORE_WIDTH-1:0] score_o,
    output logic [LIFE_WIDTH-1:0]  lives_o,
    output logic                   invincible_o,
    output logic                   game_over_o
);

    localparam int INV_W = $clog2(INV_FRAMES + 1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    if (LIVES_INIT < 1 || LIVES_INIT > (2 ** LIFE_WIDTH) - 1) begin : g_bad_lives
        $error("game_ctrl: LIVES_INIT out of range");
    end
    if (INV_FRAMES < 1) begin : g_bad_inv
        $error("game_ctrl: INV_FRAMES must be at least 1");
    end

    state_t             state;
    logic [INV_W-1:0]   inv_cnt;
    logic               bullet_seen;
    logic               me_seen;
    logic               start_pulse;
    logic               active;
    logic [SCORE_WIDTH:0]   score_sum;
    logic [SCORE_WIDTH-1:0] score_sat;

    edge_detect #(.FALLING(1'b1), .RST_LEVEL(1'b1)) u_vsync_edge (
        .clk   (clk_vga),
        .rst   (rst),
        .d     (v_sync_i),
        .pulse (frame_tick_o)
    );

    edge_detect #(.FALLING(1'b0), .RST_LEVEL(1'b0)) u_start_edge (
        .clk   (clk_vga),
        .rst   (rst),
        .d     (start_i),
        .pulse (start_pulse)
    );

    // One extra bit catches the carry so the score saturates instead of wrapping.
    always_comb begin
        active    = is_active(state);
        score_sum = {1'b0, score_o} + (SCORE_WIDTH + 1)'(HIT_SCORE);
        score_sat = score_sum[SCORE_WIDTH] ? SCORE_MAX : score_sum[SCORE_WIDTH-1:0];
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            score_o      <= '0;
            lives_o      <= LIFE_WIDTH'(LIVES_INIT);
            inv_cnt      <= '0;
            bullet_seen  <= 1'b0;
            me_seen      <= 1'b0;
            en_o         <= 1'b0;
            invincible_o <= 1'b0;
            game_over_o  <= 1'b0;
        end else begin
            // A strobe in the tick cycle starts the next frame's flags.
            if (frame_tick_o) begin
                bullet_seen <= crash_enemy_bullet_i & active;
                me_seen     <= crash_me_enemy_i & active;
            end else begin
                bullet_seen <= bullet_seen | (crash_enemy_bullet_i & active);
                me_seen     <= me_seen | (crash_me_enemy_i & active);
            end

            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_pulse) begin
                        state        <= ST_PLAY;
                        score_o      <= '0;
                        lives_o      <= LIFE_WIDTH'(LIVES_INIT);
                        inv_cnt      <= '0;
                        bullet_seen  <= 1'b0;
                        me_seen      <= 1'b0;
                        en_o         <= 1'b1;
                        invincible_o <= 1'b0;
                        game_over_o  <= 1'b0;
                    end
                end

                ST_PLAY: begin
                    if (frame_tick_o) begin
                        if (bullet_seen) begin
                            score_o <= score_sat;
                        end
                        if (me_seen) begin
                            lives_o <= lives_o - LIFE_WIDTH'(1);
                            if (lives_o == LIFE_WIDTH'(1)) begin
                                state       <= ST_OVER;
                                en_o        <= 1'b0;
                                game_over_o <= 1'b1;
                            end else begin
                                state        <= ST_HIT;
                                inv_cnt      <= INV_W'(INV_FRAMES);
                                invincible_o <= 1'b1;
                            end
                        end
                    end
                end

                ST_HIT: begin
                    if (frame_tick_o) begin
                        if (bullet_seen) begin
                            score_o <= score_sat;
                        end
                        if (inv_cnt == INV_W'(1)) begin
                            state        <= ST_PLAY;
                            inv_cnt      <= '0;
                            invincible_o <= 1'b0;
                        end else begin
                            inv_cnt <= inv_cnt - INV_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised frame-level bench for game_ctrl with a behavioural game model.
module tb_game_ctrl;

    localparam int SW   = 4;
    localparam int LW   = 2;
    localparam int LI   = 3;
    localparam int INV  = 4;
    localparam int HS   = 1;
    localparam int SMAX = (1 << SW) - 1;
    localparam int VW   = 3 + LW + SW;

    logic          clk_vga = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          v_sync_i = 1'b1;
    logic          crash_enemy_bullet_i = 1'b0;
    logic          crash_me_enemy_i = 1'b0;
    logic          en_o;
    logic          frame_tick_o;
    logic [SW-1:0] score_o;
    logic [LW-1:0] lives_o;
    logic          invincible_o;
    logic          game_over_o;

    int total = 0;
    int bad   = 0;

    // Game model: playing/over flags, score, lives, frames of invincibility left.
    bit m_play, m_over, m_pend_b;
    int m_score, m_lives, m_inv;
    logic [VW-1:0] exp_q[$];

    game_ctrl #(
        .SCORE_WIDTH (SW),
        .LIFE_WIDTH  (LW),
        .LIVES_INIT  (LI),
        .HIT_SCORE   (HS),
        .INV_FRAMES  (INV)
    ) dut (
        .clk_vga              (clk_vga),
        .rst                  (rst),
        .start_i              (start_i),
        .v_sync_i             (v_sync_i),
        .crash_enemy_bullet_i (crash_enemy_bullet_i),
        .crash_me_enemy_i     (crash_me_enemy_i),
        .en_o                 (en_o),
        .frame_tick_o         (frame_tick_o),
        .score_o              (score_o),
        .lives_o              (lives_o),
        .invincible_o         (invincible_o),
        .game_over_o          (game_over_o)
    );

    always #5 clk_vga = ~clk_vga;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [VW-1:0] obs_vec();
        return {en_o, invincible_o, game_over_o, lives_o, score_o};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_play, (m_inv > 0), m_over, LW'(m_lives), SW'(m_score)};
    endfunction

    function automatic void model_reset();
        m_play = 0; m_over = 0; m_pend_b = 0;
        m_score = 0; m_lives = LI; m_inv = 0;
    endfunction

    function automatic void model_start();
        if (!m_play) begin
            m_play = 1; m_over = 0; m_pend_b = 0;
            m_score = 0; m_lives = LI; m_inv = 0;
        end
    endfunction

    function automatic void model_frame(input bit b, input bit m);
        if (!m_play) return;
        if (b) m_score = (m_score + HS > SMAX) ? SMAX : m_score + HS;
        if (m_inv > 0) begin
            m_inv--;
        end else if (m) begin
            m_lives--;
            if (m_lives == 0) begin
                m_play = 0;
                m_over = 1;
            end else begin
                m_inv = INV;
            end
        end
    endfunction

    task automatic cyc();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic press_start(output logic en_a, output logic en_b);
        start_i = 1'b1;
        cyc();
        en_a = en_o;
        start_i = 1'b0;
        cyc();
        en_b = en_o;
        model_start();
        repeat (2) cyc();
    endtask

    // One frame: v_sync high with strobe bursts, then four low cycles.
    task automatic run_frame(input int nb, input int nm, input bit tick_b,
                             output logic t1, output logic t_rest,
                             output logic [VW-1:0] v_tick, output logic [VW-1:0] v_after);
        int h, bp, mp;
        bit fb, fm;
        h = $urandom_range(10, 25);
        if (nb + 6 > h) h = nb + 6;
        if (nm + 6 > h) h = nm + 6;
        bp = $urandom_range(2, h - nb - 2);
        mp = $urandom_range(2, h - nm - 2);
        for (int i = 0; i < h; i++) begin
            v_sync_i = 1'b1;
            crash_enemy_bullet_i = (i >= bp) && (i < bp + nb);
            crash_me_enemy_i     = (i >= mp) && (i < mp + nm);
            cyc();
        end
        crash_enemy_bullet_i = 1'b0;
        crash_me_enemy_i     = 1'b0;
        v_sync_i = 1'b0;
        cyc();
        t1     = frame_tick_o;
        v_tick = obs_vec();
        crash_enemy_bullet_i = tick_b;
        cyc();
        t_rest  = frame_tick_o;
        v_after = obs_vec();
        fb = (nb > 0) || m_pend_b;
        fm = (nm > 0);
        m_pend_b = tick_b && m_play;
        model_frame(fb, fm);
        exp_q.push_back(model_vec());
        crash_enemy_bullet_i = 1'b0;
        repeat (2) begin
            cyc();
            t_rest = t_rest | frame_tick_o;
        end
        v_sync_i = 1'b1;
    endtask

    task automatic test_reset();
        logic t1, tr;
        logic [VW-1:0] vt, va, e;
        logic ea, eb;
        rst = 1'b1;
        model_reset();
        repeat (3) cyc();
        total++;
        if (obs_vec() !== model_vec() || frame_tick_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: got %h tick=%b expected %h tick=0", obs_vec(), frame_tick_o, model_vec());
        end
        @(negedge clk_vga);
        rst = 1'b0;
        press_start(ea, eb);
        run_frame(2, 2, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (va !== e) begin
            bad++;
            $display("FAIL reset_pregame: got %h expected %h", va, e);
        end
        // Assert reset between clock edges and look before the next edge.
        @(posedge clk_vga);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== model_vec() || frame_tick_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got %h expected %h", obs_vec(), model_vec());
        end
        repeat (2) cyc();
        @(negedge clk_vga);
        rst = 1'b0;
        for (int f = 0; f < 3; f++) begin
            run_frame($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, t1, tr, vt, va);
            e = exp_q.pop_front();
            total++;
            if (va !== e || t1 !== 1'b1) begin
                bad++;
                $display("FAIL idle_frames: frame %0d got %h tick=%b expected %h tick=1", f, va, t1, e);
            end
        end
    endtask

    task automatic test_start_tick();
        logic t1, tr, ea, eb;
        logic [VW-1:0] vt, va, e;
        press_start(ea, eb);
        total++;
        if (ea !== 1'b0 || eb !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: got en=%b,%b expected 0,1", ea, eb);
        end
        run_frame(0, 0, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (t1 !== 1'b1 || tr !== 1'b0 || va !== e) begin
            bad++;
            $display("FAIL tick_pulse: got tick=%b rest=%b vec=%h expected tick=1 rest=0 vec=%h", t1, tr, va, e);
        end
    endtask

    task automatic test_dedup();
        logic t1, tr;
        logic [VW-1:0] vt, va, e, pre;
        pre = model_vec();
        run_frame(500, 0, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (vt !== pre || va !== e) begin
            bad++;
            $display("FAIL dedup_500: got at_tick=%h after=%h expected %h then %h", vt, va, pre, e);
        end
        run_frame(0, 0, 1'b1, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (va !== e) begin
            bad++;
            $display("FAIL tick_strobe_same_frame: got %h expected %h", va, e);
        end
        run_frame(0, 0, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (va !== e) begin
            bad++;
            $display("FAIL tick_strobe_next_frame: got %h expected %h", va, e);
        end
    endtask

    task automatic test_life_loss();
        logic t1, tr;
        logic [VW-1:0] vt, va, e;
        int inv_ticks;
        inv_ticks = 0;
        run_frame(0, 3, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (va !== e) begin
            bad++;
            $display("FAIL life_loss: got %h expected %h", va, e);
        end
        for (int f = 0; f < INV + 1; f++) begin
            run_frame($urandom_range(0, 2), (f < INV) ? $urandom_range(1, 3) : 0, 1'b0, t1, tr, vt, va);
            if (vt[VW-2] === 1'b1) inv_ticks++;
            e = exp_q.pop_front();
            total++;
            if (va !== e) begin
                bad++;
                $display("FAIL hit_frame: frame %0d got %h expected %h", f, va, e);
            end
        end
        total++;
        if (inv_ticks != INV || invincible_o !== 1'b0 || en_o !== 1'b1) begin
            bad++;
            $display("FAIL inv_length: got ticks=%0d inv=%b en=%b expected ticks=%0d inv=0 en=1",
                     inv_ticks, invincible_o, en_o, INV);
        end
    endtask

    task automatic test_game_over();
        logic t1, tr, ea, eb;
        logic [VW-1:0] vt, va, e;
        for (int f = 0; f < 40 && !m_over; f++) begin
            run_frame($urandom_range(0, 1), (m_inv == 0) ? 1 : 0, 1'b0, t1, tr, vt, va);
            e = exp_q.pop_front();
            total++;
            if (va !== e) begin
                bad++;
                $display("FAIL lose_lives: frame %0d got %h expected %h", f, va, e);
            end
        end
        total++;
        if (lives_o !== '0 || game_over_o !== 1'b1 || en_o !== 1'b0) begin
            bad++;
            $display("FAIL over_state: got lives=%0d over=%b en=%b expected 0,1,0", lives_o, game_over_o, en_o);
        end
        for (int f = 0; f < 3; f++) begin
            run_frame($urandom_range(1, 4), $urandom_range(1, 4), 1'b0, t1, tr, vt, va);
            e = exp_q.pop_front();
            total++;
            if (va !== e) begin
                bad++;
                $display("FAIL over_hold: frame %0d got %h expected %h", f, va, e);
            end
        end
        press_start(ea, eb);
        total++;
        if (eb !== 1'b1 || obs_vec() !== model_vec()) begin
            bad++;
            $display("FAIL restart: got en=%b vec=%h expected en=1 vec=%h", eb, obs_vec(), model_vec());
        end
    endtask

    task automatic test_simultaneous();
        logic t1, tr;
        logic [VW-1:0] vt, va, e;
        run_frame(3, 2, 1'b0, t1, tr, vt, va);
        e = exp_q.pop_front();
        total++;
        if (va !== e) begin
            bad++;
            $display("FAIL both_crashes: got %h expected %h", va, e);
        end
    endtask

    task automatic test_saturation();
        logic t1, tr;
        logic [VW-1:0] vt, va, e;
        for (int f = 0; f < 20; f++) begin
            run_frame($urandom_range(1, 40), 0, 1'b0, t1, tr, vt, va);
            e = exp_q.pop_front();
            total++;
            if (va !== e) begin
                bad++;
                $display("FAIL saturate_frame: frame %0d got %h expected %h", f, va, e);
            end
        end
        total++;
        if (score_o !== SW'(SMAX)) begin
            bad++;
            $display("FAIL saturate_value: got %0d expected %0d", score_o, SMAX);
        end
    endtask

    task automatic test_random();
        logic t1, tr, ea, eb;
        logic [VW-1:0] vt, va, e;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) begin
                press_start(ea, eb);
                total++;
                if (obs_vec() !== model_vec()) begin
                    bad++;
                    $display("FAIL rand_start: step %0d got %h expected %h", f, obs_vec(), model_vec());
                end
            end
            run_frame(($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      1'($urandom_range(0, 1)), t1, tr, vt, va);
            e = exp_q.pop_front();
            total++;
            if (va !== e || t1 !== 1'b1 || tr !== 1'b0) begin
                bad++;
                $display("FAIL rand_frame: step %0d got %h tick=%b rest=%b expected %h", f, va, t1, tr, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_dedup();
        test_life_loss();
        test_game_over();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
